// File: rtl/mem_sdp_pkg.sv
// rtl/mem_sdp_pkg.sv - shared types and helpers for the mem_sdp_be memory
//
// Holds the controller state encoding and the lane helpers used by
// mem_sdp_be. Helpers work on fixed maximum widths; callers cast the
// results down to their real word width.
package mem_sdp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int MAX_BYTES = 32;
  localparam int MAX_WIDTH = 256;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Expands per-lane enables into a per-bit mask.
  function automatic logic [MAX_WIDTH-1:0] lane_mask(input logic [MAX_BYTES-1:0] be,
                                                     input int byte_width);
    logic [MAX_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if ((i / byte_width) < MAX_BYTES) begin
        mask[i] = be[i / byte_width];
      end
    end
    return mask;
  endfunction

  // Even parity per lane: the returned bit makes the lane plus parity even.
  function automatic logic [MAX_BYTES-1:0] lane_parity(input logic [MAX_WIDTH-1:0] data,
                                                       input int nbytes,
                                                       input int byte_width);
    logic [MAX_BYTES-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < nbytes * byte_width) begin
        par[i / byte_width] = par[i / byte_width] ^ data[i];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/mem_sdp_array.sv
// rtl/mem_sdp_array.sv - raw storage with byte-lane write port and combinational read
//
// Ports:
//   clk            write clock (rising edge)
//   we, wbe        write strobe and per-lane enables
//   waddr, wdata   write address and lane-packed write word
//   raddr, rdata   combinational read; out-of-range addresses return zero
// The array has no reset: contents are only changed by writes.
module mem_sdp_array #(
  parameter int LANE_WIDTH = 8,
  parameter int NUM_LANES  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_SIZE   = 32
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [NUM_LANES-1:0]            wbe,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]           raddr,
  output logic [NUM_LANES*LANE_WIDTH-1:0] rdata
);

  localparam int WORD_WIDTH = NUM_LANES * LANE_WIDTH;

  logic [WORD_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Extra address bit so MEM_SIZE == 2**ADDR_WIDTH does not wrap to zero.
  assign rdata = ({1'b0, raddr} < (ADDR_WIDTH+1)'(MEM_SIZE)) ? mem[raddr] : '0;

endmodule

// File: rtl/mem_sdp_be.sv
// rtl/mem_sdp_be.sv - simple-dual-port RAM with byte enables, clear engine and read pipeline
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   clear_req / clear_busy      request a zeroing sweep / sweep in progress
//   write_en, write_be,         byte-enabled write port, accepted when write_ready
//   write_address, data_in,
//   write_ready
//   read_en, read_address,      read port, accepted when read_ready
//   read_ready
//   data_out, data_valid        read result, READ_LATENCY cycles after accept
//   parity_err                  only with MEM_SDP_PARITY_EN: stored lane parity mismatch
//
// Optional feature macro: MEM_SDP_PARITY_EN adds one even-parity bit per lane.
module mem_sdp_be
  import mem_sdp_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_SIZE     = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_req,
  output logic                             clear_busy,
  input  logic                             write_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_be,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic                             write_ready,
  input  logic                             read_en,
  input  logic [ADDR_WIDTH-1:0]            read_address,
  output logic                             read_ready,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid
`ifdef MEM_SDP_PARITY_EN
  ,
  output logic                             parity_err
`endif
);

  localparam int NB = num_bytes(DATA_WIDTH, BYTE_WIDTH);
`ifdef MEM_SDP_PARITY_EN
  localparam int LW = BYTE_WIDTH + 1;
`else
  localparam int LW = BYTE_WIDTH;
`endif
  localparam int SW = NB * LW;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  logic                  wr_acc, rd_acc;
  logic                  wr_in_range, rd_in_range, coll;
  logic [DATA_WIDTH-1:0] mask, rd_data, rd_word;
  logic [SW-1:0]         wr_packed, arr_wdata, arr_rdata;
  logic [NB-1:0]         arr_be;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic                  arr_we;
  logic                  rd_err;

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid, s1_err;

  // ---------------------------------------------------------------------
  // Controller: CLEAR sweeps one word per cycle, IDLE serves requests.
  // Ready/busy are registered alongside the state so they track it exactly.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      write_ready <= 1'b0;
      read_ready  <= 1'b0;
      clear_busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            write_ready <= 1'b1;
            read_ready  <= 1'b1;
            clear_busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            write_ready <= 1'b0;
            read_ready  <= 1'b0;
            clear_busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign wr_acc      = write_en & write_ready;
  assign rd_acc      = read_en & read_ready;
  assign wr_in_range = {1'b0, write_address} < (ADDR_WIDTH+1)'(MEM_SIZE);
  assign rd_in_range = {1'b0, read_address} < (ADDR_WIDTH+1)'(MEM_SIZE);
  assign coll        = wr_acc & wr_in_range & (write_address == read_address);
  assign mask        = DATA_WIDTH'(lane_mask(MAX_BYTES'(write_be), BYTE_WIDTH));

`ifdef MEM_SDP_PARITY_EN
  logic [NB-1:0] wr_par, rd_par, rd_par_eff;
  assign wr_par = NB'(lane_parity(MAX_WIDTH'(data_in), NB, BYTE_WIDTH));
`endif

  // Lane packing between the data word and the storage word.
  always_comb begin
    wr_packed = '0;
    rd_data   = '0;
`ifdef MEM_SDP_PARITY_EN
    rd_par    = '0;
`endif
    for (int i = 0; i < NB; i++) begin
`ifdef MEM_SDP_PARITY_EN
      wr_packed[i*LW +: LW] = {wr_par[i], data_in[i*BYTE_WIDTH +: BYTE_WIDTH]};
      rd_par[i]             = arr_rdata[i*LW + BYTE_WIDTH];
`else
      wr_packed[i*LW +: LW] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
      rd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = arr_rdata[i*LW +: BYTE_WIDTH];
    end
  end

  // The sweep owns the write port while clearing; user writes only land in IDLE.
  always_comb begin
    arr_we    = 1'b0;
    arr_be    = '0;
    arr_addr  = write_address;
    arr_wdata = '0;
    if (state == ST_CLEAR) begin
      arr_we   = 1'b1;
      arr_be   = '1;
      arr_addr = cnt;
    end else if (wr_acc && wr_in_range) begin
      arr_we    = 1'b1;
      arr_be    = write_be;
      arr_wdata = wr_packed;
    end
  end

  mem_sdp_array #(
    .LANE_WIDTH (LW),
    .NUM_LANES  (NB),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .wbe   (arr_be),
    .waddr (arr_addr),
    .wdata (arr_wdata),
    .raddr (read_address),
    .rdata (arr_rdata)
  );

  // Write-first: a same-cycle write to the read address supplies the enabled lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = coll ? ((data_in & mask) | (rd_data & ~mask)) : rd_data;
    end
  end

`ifdef MEM_SDP_PARITY_EN
  assign rd_par_eff = coll ? ((wr_par & write_be) | (rd_par & ~write_be)) : rd_par;
  assign rd_err     = rd_in_range &
                      (|(NB'(lane_parity(MAX_WIDTH'(rd_word), NB, BYTE_WIDTH)) ^ rd_par_eff));
`else
  assign rd_err     = 1'b0;
`endif

  // Stage 1 captures the read at acceptance, so a clear started afterwards
  // cannot disturb reads already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
        s1_err  <= rd_err;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid, s2_err;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
            s2_err  <= s1_err;
          end
        end
      end
      assign data_out   = s2_data;
      assign data_valid = s2_valid;
`ifdef MEM_SDP_PARITY_EN
      assign parity_err = s2_valid & s2_err;
`endif
    end else begin : g_lat1
      assign data_out   = s1_data;
      assign data_valid = s1_valid;
`ifdef MEM_SDP_PARITY_EN
      assign parity_err = s1_valid & s1_err;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_mem_sdp_be.sv
// tb/tb_mem_sdp_be.sv - scoreboard bench for mem_sdp_be (three configurations)
module tb_mem_sdp_be;

  typedef struct {
    logic [15:0] d;
    int          c;
    logic        pe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, clear_req, write_en, read_en;
  logic [1:0]  write_be;
  logic [4:0]  write_address, read_address;
  logic [15:0] data_in;
  logic [2:0]  busy, wrdy, rrdy, dv, pe;
  logic [15:0] dout_a, dout_b, dout_c;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic [15:0] mdl [3][32];
  int          msz [3] = '{32, 32, 24};
  int          lat [3] = '{1, 2, 1};
  int          clr_end [3];
  logic [15:0] last [3];
  logic        bad9 = 1'b0;
  exp_t        qa [$];
  exp_t        qb [$];
  exp_t        qc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifndef MEM_SDP_PARITY_EN
  assign pe = 3'b000;
`endif

  mem_sdp_be #(.MEM_SIZE(32), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(busy[0]),
    .write_en(write_en), .write_be(write_be), .write_address(write_address),
    .data_in(data_in), .write_ready(wrdy[0]), .read_en(read_en),
    .read_address(read_address), .read_ready(rrdy[0]), .data_out(dout_a),
    .data_valid(dv[0])
`ifdef MEM_SDP_PARITY_EN
    , .parity_err(pe[0])
`endif
  );

  mem_sdp_be #(.MEM_SIZE(32), .READ_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(busy[1]),
    .write_en(write_en), .write_be(write_be), .write_address(write_address),
    .data_in(data_in), .write_ready(wrdy[1]), .read_en(read_en),
    .read_address(read_address), .read_ready(rrdy[1]), .data_out(dout_b),
    .data_valid(dv[1])
`ifdef MEM_SDP_PARITY_EN
    , .parity_err(pe[1])
`endif
  );

  mem_sdp_be #(.MEM_SIZE(24), .READ_LATENCY(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(busy[2]),
    .write_en(write_en), .write_be(write_be), .write_address(write_address),
    .data_in(data_in), .write_ready(wrdy[2]), .read_en(read_en),
    .read_address(read_address), .read_ready(rrdy[2]), .data_out(dout_c),
    .data_valid(dv[2])
`ifdef MEM_SDP_PARITY_EN
    , .parity_err(pe[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = old;
    if (be[0]) m[7:0]  = nw[7:0];
    if (be[1]) m[15:8] = nw[15:8];
    return m;
  endfunction

  // Compare one DUT output against its scoreboard queue.
  task automatic mon(input int i, input logic v, input logic [15:0] d, input logic p);
    exp_t e;
    int   n;
    n = (i == 0) ? qa.size() : (i == 1) ? qb.size() : qc.size();
    if (!v) begin
      chk($sformatf("hold%0d", i), {16'h0, d}, {16'h0, last[i]});
    end else if (n == 0) begin
      chk($sformatf("spurious_valid%0d", i), 32'd1, 32'd0);
    end else begin
      case (i)
        0:       e = qa.pop_front();
        1:       e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      chk($sformatf("data%0d", i), {16'h0, d}, {16'h0, e.d});
      chk($sformatf("latency%0d", i), 32'(cyc), 32'(e.c));
`ifdef MEM_SDP_PARITY_EN
      chk($sformatf("parity_err%0d", i), {31'h0, p}, {31'h0, e.pe});
`endif
      last[i] = d;
    end
    if (!v || n == 0) begin
`ifdef MEM_SDP_PARITY_EN
      chk($sformatf("parity_idle%0d", i), {31'h0, p}, 32'd0);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, dv[0], dout_a, pe[0]);
      mon(1, dv[1], dout_b, pe[1]);
      mon(2, dv[2], dout_c, pe[2]);
    end
  end

  // One stimulus cycle: drive at the negedge, update each model, advance.
  task automatic op(input logic we, input logic [1:0] be, input logic [4:0] wa,
                    input logic [15:0] d, input logic re, input logic [4:0] ra,
                    input logic clr);
    exp_t e;
    write_en = we; write_be = be; write_address = wa; data_in = d;
    read_en = re; read_address = ra; clear_req = clr;
    for (int i = 0; i < 3; i++) begin
      if (cyc + 1 > clr_end[i]) begin
        if (re) begin
          e.d = (int'(ra) < msz[i]) ? mdl[i][ra] : 16'h0;
          if (we && wa == ra && int'(wa) < msz[i]) e.d = merge(mdl[i][ra], d, be);
          e.c  = cyc + lat[i];
          e.pe = (i == 0) && bad9 && (ra == 5'd9);
          case (i)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
          endcase
        end
        if (we && int'(wa) < msz[i]) begin
          mdl[i][wa] = merge(mdl[i][wa], d, be);
          if (i == 0 && wa == 5'd9 && be[0]) bad9 = 1'b0;
        end
        if (clr) begin
          clr_end[i] = cyc + 1 + msz[i];
          for (int j = 0; j < 32; j++) mdl[i][j] = 16'h0;
          if (i == 0) bad9 = 1'b0;
        end
      end
    end
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) op(1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int nb [3];
    int n;
    rst_n = 1'b0; clear_req = 1'b0; write_en = 1'b0; read_en = 1'b0;
    write_be = 2'b00; write_address = 5'd0; read_address = 5'd0; data_in = 16'h0;
    for (int i = 0; i < 3; i++) begin
      last[i] = 16'h0; nb[i] = 0;
      for (int j = 0; j < 32; j++) mdl[i][j] = 16'h0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", {29'h0, busy}, 32'h7);
    chk("rst_wrdy", {29'h0, wrdy}, 32'h0);
    chk("rst_rrdy", {29'h0, rrdy}, 32'h0);
    chk("rst_valid", {29'h0, dv}, 32'h0);
    chk("rst_dout", {dout_a, dout_b}, 32'h0);
    chk("rst_dout_c", {16'h0, dout_c}, 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) clr_end[i] = cyc + msz[i];
    n = 0;
    while (busy != 3'b000 && n < 100) begin
      for (int i = 0; i < 3; i++) if (busy[i]) nb[i]++;
      n++;
      @(negedge clk);
    end
    chk("sweep_len_a", 32'(nb[0]), 32'd32);
    chk("sweep_len_b", 32'(nb[1]), 32'd32);
    chk("sweep_len_c", 32'(nb[2]), 32'd24);
    chk("ready_after_sweep", {26'h0, wrdy, rrdy}, 32'h3F);

    // Freshly cleared array, back-to-back reads over the whole address range.
    for (int a = 0; a < 32; a++) op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'(a), 1'b0);

    op(1'b1, 2'b11, 5'd5, 16'hBEEF, 1'b0, 5'd0, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd5, 1'b0);

    // Collision and byte-lane merging.
    op(1'b1, 2'b11, 5'd3, 16'h1234, 1'b0, 5'd0, 1'b0);
    op(1'b1, 2'b10, 5'd3, 16'hAB00, 1'b1, 5'd3, 1'b0);
    op(1'b1, 2'b00, 5'd3, 16'hFFFF, 1'b0, 5'd0, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd3, 1'b0);
    op(1'b1, 2'b01, 5'd4, 16'h00CD, 1'b1, 5'd4, 1'b0);

    // Range boundary for the 24-word instance.
    op(1'b1, 2'b11, 5'd23, 16'h2323, 1'b0, 5'd0, 1'b0);
    op(1'b1, 2'b11, 5'd30, 16'h5555, 1'b0, 5'd0, 1'b0);
    op(1'b1, 2'b11, 5'd24, 16'h2424, 1'b1, 5'd24, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd30, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd23, 1'b0);

    // Random traffic without clears.
    for (int k = 0; k < 300; k++)
      op(1'($urandom), 2'($urandom), 5'($urandom), 16'($urandom),
         1'($urandom), 5'($urandom), 1'b0);

    // Fill, then clear with reads in flight and a same-cycle write.
    for (int a = 0; a < 32; a++) op(1'b1, 2'b11, 5'(a), 16'hFFFF, 1'b0, 5'd0, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd31, 1'b0);
    op(1'b1, 2'b11, 5'd17, 16'h1717, 1'b1, 5'd30, 1'b1);
    idle(3);
    op(1'b1, 2'b11, 5'd2, 16'h0202, 1'b1, 5'd17, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 5'd0, 1'b1);
    idle(40);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd17, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd2, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd31, 1'b0);

`ifdef MEM_SDP_PARITY_EN
    op(1'b1, 2'b11, 5'd9, 16'h0909, 1'b0, 5'd0, 1'b0);
    idle(1);
    dut_a.u_array.mem[9][8] = ~dut_a.u_array.mem[9][8];
    bad9 = 1'b1;
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd9, 1'b0);
    op(1'b1, 2'b01, 5'd9, 16'h0011, 1'b0, 5'd0, 1'b0);
    op(1'b0, 2'b00, 5'd0, 16'h0, 1'b1, 5'd9, 1'b0);
`endif

    idle(6);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    chk("drain_c", 32'(qc.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
